// File: rtl/jpeg_pkg.sv
// Shared constants and helpers for the JPEG dequantise / de-zigzag stage.
// Holds the zigzag-to-natural ROM and the 16-bit saturating clamp.
package jpeg_pkg;

  localparam int NUM_TABLES = 4;
  localparam int TSEL_W     = 2;
  localparam int IDX_W      = 6;
  localparam int COEF_W     = 16;
  localparam int QUANT_W    = 8;
  localparam int PROD_W     = COEF_W + QUANT_W + 1;
  localparam int RAM_AW     = TSEL_W + IDX_W;

  localparam logic signed [PROD_W-1:0] SAT_MAX = 25'sd32767;
  localparam logic signed [PROD_W-1:0] SAT_MIN = -25'sd32768;

  localparam logic [IDX_W-1:0] ZZ_NAT [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [IDX_W-1:0] zz_to_nat(
    input logic [IDX_W-1:0] zz
  );
    return ZZ_NAT[zz];
  endfunction

  function automatic logic signed [COEF_W-1:0] sat16(
    input logic signed [PROD_W-1:0] p
  );
    if (p > SAT_MAX)
      return 16'sh7fff;
    else if (p < SAT_MIN)
      return 16'sh8000;
    else
      return p[COEF_W-1:0];
  endfunction

endpackage

// File: rtl/jpeg_dqt_ram.sv
// Quant table store: single-port synchronous RAM, write wins over read.
// Read data only changes on a read strobe so a stalled consumer keeps it.
module jpeg_dqt_ram
  import jpeg_pkg::*;
(
  input  logic              clk_i,
  input  logic              we,
  input  logic              re,
  input  logic [RAM_AW-1:0] addr,
  input  logic [QUANT_W-1:0] wdata,
  output logic [QUANT_W-1:0] rdata
);

  logic [QUANT_W-1:0] mem [2**RAM_AW];

  always_ff @(posedge clk_i) begin
    if (we)
      mem[addr] <= wdata;
    else if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/jpeg_dqt_dezigzag.sv
// Dequantise, saturate and de-zigzag decoded coefficients for the IDCT.
// Two stages: table read + capture, then multiply/clamp/remap into output.
module jpeg_dqt_dezigzag
  import jpeg_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              img_start_i,
  input  logic              dqt_valid_i,
  input  logic [TSEL_W-1:0] dqt_table_i,
  input  logic [IDX_W-1:0]  dqt_idx_i,
  input  logic [QUANT_W-1:0] dqt_data_i,
  input  logic              inport_valid_i,
  input  logic [COEF_W-1:0] inport_data_i,
  input  logic [IDX_W-1:0]  inport_idx_i,
  input  logic              inport_eob_i,
  input  logic [TSEL_W-1:0] inport_table_i,
  output logic              inport_accept_o,
  output logic              outport_valid_o,
  output logic [COEF_W-1:0] outport_data_o,
  output logic [IDX_W-1:0]  outport_idx_o,
  output logic              outport_eob_o,
  input  logic              outport_accept_i
);

  logic                     run_q;
  logic                     s1_valid_q;
  logic signed [COEF_W-1:0] s1_coef_q;
  logic [IDX_W-1:0]         s1_idx_q;
  logic                     s1_eob_q;
  logic                     out_valid_q;
  logic signed [COEF_W-1:0] out_data_q;
  logic [IDX_W-1:0]         out_idx_q;
  logic                     out_eob_q;

  logic                     advance;
  logic                     accept;
  logic [RAM_AW-1:0]        ram_addr;
  logic [QUANT_W-1:0]       quant;
  logic signed [PROD_W-1:0] prod;

  assign advance = !out_valid_q || outport_accept_i;

  // run_q keeps the input closed through reset and its first clock
  assign accept = run_q && !dqt_valid_i && !img_start_i
                  && (!s1_valid_q || advance);

  assign ram_addr = dqt_valid_i ? {dqt_table_i, dqt_idx_i}
                                : {inport_table_i, inport_idx_i};

  jpeg_dqt_ram u_ram (
    .clk_i (clk_i),
    .we    (dqt_valid_i),
    .re    (accept),
    .addr  (ram_addr),
    .wdata (dqt_data_i),
    .rdata (quant)
  );

  assign prod = PROD_W'(s1_coef_q)
              * PROD_W'($signed({1'b0, quant}));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      run_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_coef_q  <= '0;
      s1_idx_q   <= '0;
      s1_eob_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (img_start_i)
        s1_valid_q <= 1'b0;
      else if (accept)
        s1_valid_q <= inport_valid_i;
      else if (advance)
        s1_valid_q <= 1'b0;
      if (accept && inport_valid_i) begin
        s1_coef_q <= inport_data_i;
        s1_idx_q  <= inport_idx_i;
        s1_eob_q  <= inport_eob_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_eob_q   <= 1'b0;
    end else if (img_start_i) begin
      out_valid_q <= 1'b0;
    end else if (advance) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= sat16(prod);
        out_idx_q  <= zz_to_nat(s1_idx_q);
        out_eob_q  <= s1_eob_q;
      end
    end
  end

  assign inport_accept_o = accept;
  assign outport_valid_o = out_valid_q;
  assign outport_data_o  = out_data_q;
  assign outport_idx_o   = out_idx_q;
  assign outport_eob_o   = out_eob_q;

endmodule
